// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle Hack-style CPU with req/ack instruction and data ports,
// programmable reset vector and a retired-instruction counter.
module cpu_mc #(
  parameter int DW     = 16,
  parameter int AW     = 15,
  parameter int PW     = 15,
  parameter int CW     = 32,
  parameter int RST_PC = 0
) (
  input  logic          clk50m,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [PW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic [PW-1:0] pc,
  output logic [CW-1:0] instret
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MREAD, S_EXEC, S_MWRITE} state_t;
  state_t        r_state, w_next;
  logic [DW-1:0] r_a, r_d, r_ir, r_mdr;
  logic [PW-1:0] r_pc;
  logic [CW-1:0] r_instret;
  logic [DW-1:0] w_x0, w_x, w_y0, w_y, w_sum, w_out;
  logic          w_is_c, w_am, w_zr, w_ng, w_jump, w_commit;
  assign w_is_c = r_ir[DW-1];
  assign w_am   = r_ir[12];
  assign w_x0   = r_ir[11] ? '0 : r_d;
  assign w_x    = r_ir[10] ? ~w_x0 : w_x0;
  assign w_y0   = r_ir[9] ? '0 : (w_am ? r_mdr : r_a);
  assign w_y    = r_ir[8] ? ~w_y0 : w_y0;
  assign w_sum  = r_ir[7] ? w_x + w_y : w_x & w_y;
  assign w_out  = r_ir[6] ? ~w_sum : w_sum;
  assign w_zr   = w_out == '0;
  assign w_ng   = w_out[DW-1];
  assign w_jump = w_is_c & ((r_ir[2] & w_ng) | (r_ir[1] & w_zr) | (r_ir[0] & ~w_ng & ~w_zr));
  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    case (r_state)
      S_FETCH:  w_next = imem_ack ? S_DECODE : S_FETCH;
      S_DECODE: begin
        w_next   = !w_is_c ? S_FETCH : w_am ? S_MREAD : r_ir[3] ? S_MWRITE : S_FETCH;
        w_commit = !w_is_c || (!w_am && !r_ir[3]);
      end
      S_MREAD:  w_next = dmem_ack ? S_EXEC : S_MREAD;
      S_EXEC: begin
        w_next   = r_ir[3] ? S_MWRITE : S_FETCH;
        w_commit = !r_ir[3];
      end
      S_MWRITE: begin
        w_next   = dmem_ack ? S_FETCH : S_MWRITE;
        w_commit = dmem_ack;
      end
      default:  w_next = S_FETCH;
    endcase
  end
  // requests are gated by rst_n so they drop the instant reset asserts
  assign imem_req   = rst_n && r_state == S_FETCH;
  assign imem_addr  = r_pc;
  assign dmem_req   = rst_n && (r_state == S_MREAD || r_state == S_MWRITE);
  assign dmem_we    = r_state == S_MWRITE;
  assign dmem_addr  = r_a[AW-1:0];
  assign dmem_wdata = w_out;
  assign pc         = r_pc;
  assign instret    = r_instret;
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_a       <= '0;
      r_d       <= '0;
      r_ir      <= '0;
      r_mdr     <= '0;
      r_pc      <= PW'(RST_PC);
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && imem_ack) r_ir <= imem_rdata;
      if (r_state == S_MREAD && dmem_ack) r_mdr <= dmem_rdata;
      if (w_commit) begin
        if (!w_is_c) r_a <= r_ir;
        else if (r_ir[5]) r_a <= w_out;
        if (w_is_c && r_ir[4]) r_d <= w_out;
        r_pc      <= w_jump ? r_a[PW-1:0] : r_pc + PW'(1);
        r_instret <= r_instret + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: scoreboard bench for cpu_mc; an ISA-level Hack model predicts
// every memory handshake while a wait-stated ROM/RAM responder serves the DUT.
module tb_cpu_mc;
  localparam int RST = 16;
  logic        clk50m = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [14:0] imem_addr, dmem_addr, pc;
  logic [15:0] imem_rdata, dmem_rdata, dmem_wdata;
  logic [31:0] instret;
  typedef struct {int k; int a; int d;} ev_t;
  ev_t         sb[$];
  logic [15:0] rom [32768];
  logic [15:0] ram [32768];
  logic [15:0] mram [32768];
  logic [15:0] ma, md;
  logic [14:0] mpc;
  int          minst;
  int          checks = 0, failures = 0, target = 0;
  int          imin = 0, imax = 0, dmin = 0, dmax = 0;
  logic [5:0]  codes [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                              6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111,
                              6'b110111, 6'b001110, 6'b110010, 6'b000010, 6'b010011,
                              6'b000111, 6'b000000, 6'b010101};

  cpu_mc #(.RST_PC(RST)) dut (
    .clk50m(clk50m), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .pc(pc), .instret(instret)
  );

  always #5 clk50m = ~clk50m;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cins(logic a, logic [5:0] c, logic [2:0] d, logic [2:0] j);
    return {3'b111, a, c, d, j};
  endfunction

  function automatic logic [15:0] rnd_ins();
    if ($urandom_range(1, 0) == 0) return {1'b0, 15'($urandom)};
    return {1'b1, 2'($urandom), 1'($urandom), codes[$urandom_range(17, 0)], 3'($urandom), 3'($urandom)};
  endfunction

  // Hack comp table, mnemonic by mnemonic
  function automatic logic [15:0] alu_ref(logic [5:0] c, logic [15:0] x, logic [15:0] y);
    case (c)
      6'b101010: return 16'd0;
      6'b111111: return 16'd1;
      6'b111010: return 16'hffff;
      6'b001100: return x;
      6'b110000: return y;
      6'b001101: return ~x;
      6'b110001: return ~y;
      6'b001111: return 16'(-x);
      6'b110011: return 16'(-y);
      6'b011111: return 16'(x + 16'd1);
      6'b110111: return 16'(y + 16'd1);
      6'b001110: return 16'(x - 16'd1);
      6'b110010: return 16'(y - 16'd1);
      6'b000010: return 16'(x + y);
      6'b010011: return 16'(x - y);
      6'b000111: return 16'(y - x);
      6'b000000: return x & y;
      6'b010101: return x | y;
      default:   return 16'hdead;
    endcase
  endfunction

  task automatic step();
    logic [15:0] ir, y, o, olda;
    logic [14:0] ad;
    bit          jmp;
    ir = rom[mpc];
    jmp = 0;
    olda = ma;
    ad = ma[14:0];
    sb.push_back('{0, int'(mpc), 0});
    if (!ir[15]) ma = ir;
    else begin
      y = ma;
      if (ir[12]) begin
        sb.push_back('{1, int'(ad), 0});
        y = mram[ad];
      end
      o = alu_ref(ir[11:6], md, y);
      if (ir[3]) begin
        sb.push_back('{2, int'(ad), int'(o)});
        mram[ad] = o;
      end
      jmp = (ir[2] && $signed(o) < 0) || (ir[1] && o == 16'd0) || (ir[0] && $signed(o) > 0);
      if (ir[5]) ma = o;
      if (ir[4]) md = o;
    end
    mpc = jmp ? olda[14:0] : mpc + 15'd1;
    minst++;
  endtask

  initial begin : resp
    int iw, dw;
    iw = 0;
    dw = 0;
    imem_ack = 0;
    dmem_ack = 0;
    imem_rdata = 0;
    dmem_rdata = 0;
    forever begin
      @(negedge clk50m);
      imem_ack = 0;
      dmem_ack = 0;
      imem_rdata = 16'($urandom);
      dmem_rdata = 16'($urandom);
      if (!rst_n) begin
        iw = int'($urandom_range(imax, imin));
        dw = int'($urandom_range(dmax, dmin));
      end else begin
        if (imem_req && int'(instret) != target) begin
          if (iw == 0) begin
            imem_ack = 1;
            imem_rdata = rom[imem_addr];
            iw = int'($urandom_range(imax, imin));
          end else iw--;
        end
        if (dmem_req) begin
          if (dw == 0) begin
            dmem_ack = 1;
            if (dmem_we) ram[dmem_addr] = dmem_wdata;
            else dmem_rdata = ram[dmem_addr];
            dw = int'($urandom_range(dmax, dmin));
          end else dw--;
        end
      end
    end
  end

  initial begin : mon
    bit          pi, pd, sw;
    logic [14:0] si, sa;
    logic [15:0] sd;
    ev_t         e;
    pi = 0;
    pd = 0;
    forever begin
      @(negedge clk50m);
      #4;
      if (!rst_n) begin
        pi = 0;
        pd = 0;
      end else begin
        if (imem_req || dmem_req) chk("req_overlap", imem_req && dmem_req, 0);
        if (pi) chk("imem_stable", {imem_req, imem_addr}, {1'b1, si});
        if (pd) chk("dmem_stable", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, {1'b1, sw, sa, sd});
        if (imem_req && imem_ack) begin
          if (sb.size() == 0) chk("sb_underflow_fetch", imem_addr, 32'hffff_ffff);
          else begin
            e = sb.pop_front();
            chk("event_kind_fetch", 0, e.k);
            chk("fetch_addr", imem_addr, e.a);
          end
        end
        if (dmem_req && dmem_ack) begin
          if (sb.size() == 0) chk("sb_underflow_dmem", dmem_addr, 32'hffff_ffff);
          else begin
            e = sb.pop_front();
            chk("event_kind_dmem", dmem_we ? 2 : 1, e.k);
            chk("dmem_addr", dmem_addr, e.a);
            if (dmem_we) chk("dmem_wdata", dmem_wdata, e.d);
          end
        end
        pi = imem_req && !imem_ack;
        si = imem_addr;
        pd = dmem_req && !dmem_ack;
        sw = dmem_we;
        sa = dmem_addr;
        sd = dmem_wdata;
      end
    end
  end

  task automatic start(int n, int i0, int i1, int d0, int d1);
    @(negedge clk50m);
    #2 rst_n = 0;
    imin = i0;
    imax = i1;
    dmin = d0;
    dmax = d1;
    repeat (2) @(negedge clk50m);
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_pc", pc, RST);
    chk("rst_instret", instret, 0);
    sb.delete();
    ma = 0;
    md = 0;
    mpc = 15'(RST);
    minst = 0;
    mram = ram;
    for (int i = 0; i < n; i++) step();
    target = n;
    rst_n = 1;
  endtask

  task automatic finish_run();
    int c = 0;
    while (int'(instret) != target && c < 4000) begin
      @(negedge clk50m);
      c++;
    end
    chk("run_reached_target", instret, target);
    repeat (4) @(negedge clk50m);
    #1;
    chk("sb_drained", sb.size(), 0);
    chk("pc", pc, mpc);
    chk("instret", instret, minst);
    chk("reg_a", dut.r_a, ma);
    chk("reg_d", dut.r_d, md);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin : main
    int c;
    for (int i = 0; i < 32768; i++) begin
      rom[i] = rnd_ins();
      ram[i] = 16'($urandom);
    end
    // @2 / D=A / @3 / D=D+A / @0 / M=D, zero wait
    rom[16] = 16'd2;
    rom[17] = cins(0, 6'b110000, 3'b010, 3'b000);
    rom[18] = 16'd3;
    rom[19] = cins(0, 6'b000010, 3'b010, 3'b000);
    rom[20] = 16'd0;
    rom[21] = cins(0, 6'b001100, 3'b001, 3'b000);
    start(6, 0, 0, 0, 0);
    finish_run();
    chk("prog_instret", instret, 6);
    chk("prog_pc", pc, 22);
    chk("prog_m0", ram[0], 5);
    // M=M+1 with wait states
    rom[16] = 16'd7;
    rom[17] = cins(1, 6'b110111, 3'b001, 3'b000);
    ram[7] = 16'd9;
    start(2, 3, 3, 2, 2);
    finish_run();
    chk("wait_m7", ram[7], 10);
    // jumps: taken JLT, untaken JGT, unconditional JMP
    rom[16] = cins(0, 6'b111010, 3'b010, 3'b000);
    rom[17] = 16'd100;
    rom[18] = cins(0, 6'b001100, 3'b000, 3'b100);
    rom[100] = cins(0, 6'b101010, 3'b010, 3'b000);
    rom[101] = 16'd200;
    rom[102] = cins(0, 6'b001100, 3'b000, 3'b001);
    rom[103] = 16'd300;
    rom[104] = cins(0, 6'b101010, 3'b000, 3'b111);
    start(8, 0, 1, 0, 1);
    finish_run();
    chk("jump_pc", pc, 300);
    // AM=M-1 writes at the old A
    rom[16] = 16'd4;
    rom[17] = cins(1, 6'b110010, 3'b101, 3'b000);
    ram[4] = 16'd1;
    start(2, 0, 0, 0, 0);
    finish_run();
    chk("am_m4", ram[4], 0);
    chk("am_a", dut.r_a, 0);
    // PC wrap at 2^PW-1
    rom[16] = 16'h7fff;
    rom[17] = cins(0, 6'b101010, 3'b000, 3'b111);
    rom[32767] = cins(0, 6'b011111, 3'b010, 3'b000);
    start(3, 0, 0, 0, 0);
    finish_run();
    chk("wrap_pc", pc, 0);
    for (int r = 0; r < 5; r++) begin
      start(40, 0, int'($urandom_range(2, 0)), 0, int'($urandom_range(2, 0)));
      finish_run();
    end
    // reset asserted while a write is waiting for its ack
    rom[16] = 16'd5;
    rom[17] = cins(0, 6'b110000, 3'b010, 3'b000);
    rom[18] = 16'd4;
    rom[19] = cins(0, 6'b001100, 3'b001, 3'b000);
    start(4, 0, 0, 6, 6);
    c = 0;
    while (!(dmem_req && dmem_we) && c < 100) begin
      @(negedge clk50m);
      c++;
    end
    chk("mwrite_seen", dmem_req && dmem_we, 1);
    chk("pre_rst_a", dut.r_a, 4);
    chk("pre_rst_d", dut.r_d, 5);
    chk("pre_rst_instret", instret, 3);
    #2 rst_n = 0;
    #1;
    chk("midrst_dmem_req", dmem_req, 0);
    chk("midrst_imem_req", imem_req, 0);
    chk("midrst_a", dut.r_a, 0);
    chk("midrst_d", dut.r_d, 0);
    chk("midrst_instret", instret, 0);
    chk("midrst_pc", pc, RST);
    sb.delete();
    target = 0;
    #1 rst_n = 1;
    #1;
    chk("post_rst_fetch", {imem_req, imem_addr}, {1'b1, 15'(RST)});
    chk("post_rst_dmem_req", dmem_req, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
